pheap_root_ctl: RTL and testbench
=================================

Name: pheap_root_ctl

Overview:
- Parametrised root-level (level 1) controller for the pipelined heap (pheap) priority queue.
- Holds the single root entry and services ENQ and DEQ, plus optional REPLACE.
- Reads both level-2 children and forwards a push-down request to level 2 through a ready handshake.
- Adds over the fixed-width root: configurable key/value width and depth, selectable min/max ordering, capacity-balanced insertion, full/empty error reporting, occupancy count and next-level back-pressure.

Parameters:
- KEY_W, 16, key width in bits.
- VAL_W, 16, value width in bits.
- LEVELS, 4, heap depth. Capacity fields are LEVELS bits wide. MAX_CAP = 2^LEVELS-1.
- MAX_HEAP, 1, ordering: 1 = largest key at root, 0 = smallest key at root.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  operation request, sampled in IDLE
- op  in  opcode_t  ENQ/DEQ/REPLACE, sampled with start
- in  in  KEY_W+VAL_W  key/value to insert
- rBotL, rBotR  in  entry_t  level-2 children, valid the cycle after raddrBot is driven
- nxt_ready  in  1  level 2 can accept a push-down
- raddrBot  out  1  level-2 read address, constant 0
- done  out  done_t  DONE/WAIT/NEXT_LEVEL
- op_out  out  opcode_t  op forwarded to level 2
- endPos  out  1  child selected for push-down (0 = left, 1 = right)
- out  out  KEY_W+VAL_W  dequeued item (DEQ/REPLACE) or item pushed down (ENQ/REPLACE)
- head_out  out  KEY_W+VAL_W  current root kv, combinational
- full, empty  out  1  root capacity == 0 / root capacity == MAX_CAP
- err  out  1  one-cycle pulse on rejected op
- count  out  LEVELS  occupancy, MAX_CAP - capacity

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: root = {KV_EMPTY, MAX_CAP, active=0}; state IDLE; done=DONE; err=0; out=KV_EMPTY; endPos=0; op_out=ENQ.
- rst dominates mid-operation: any captured op is discarded.
- Compare rule: "a beats b" means a.key > b.key if MAX_HEAP, else a.key < b.key. Equal keys never beat. An inactive entry loses to any active entry.
- FSM states: IDLE, EXEC.
- IDLE:
  - On start: capture op/in into registers, done=WAIT, go to EXEC.
  - Otherwise done=DONE.
- EXEC: children data are valid here. Minimum latency is start cycle + 1; the commit happens in EXEC.
- ENQ, full: err=1, done=DONE, no write.
- ENQ, root inactive: root={in, cap-1, 1}, done=DONE.
- ENQ, root active:
  - Winner of in vs root stays at root; loser goes on out. Tie keeps the root.
  - cap decrements.
  - endPos = child with the larger capacity; tie or both zero = left.
  - done=NEXT_LEVEL.
- DEQ, empty: err=1, out=KV_EMPTY, done=DONE.
- DEQ, non-empty: out=root.kv and cap increments.
  - Neither child active: root becomes inactive KV_EMPTY, done=DONE.
  - Otherwise the better child (tie = left) is promoted to root, endPos = its side, done=NEXT_LEVEL.
- Back-pressure: if the result is NEXT_LEVEL and nxt_ready=0, stay in EXEC, done=WAIT, no root write, no err. The commit occurs in the first EXEC cycle with nxt_ready=1.
- Output validity: out, endPos and op_out are valid only in the commit cycle. Then return to IDLE.
- start while in EXEC is ignored.

Optional Feature:
- Macro PHEAP_REPLACE_EN.
- Defined: op REPLACE pops the root and inserts in atomically; capacity unchanged.
  - If empty: behaves as ENQ with no output.
  - Otherwise out=root.kv.
  - If in beats (or ties) both active children: root=in, done=DONE.
  - Otherwise the better child is promoted, in is pushed down toward that child: endPos=its side, op_out=REPLACE, done=NEXT_LEVEL.
- Undefined: REPLACE is treated as illegal: err=1, done=DONE, no write.

Decomposition:
- pheapTypes package holds opcode_t (ENQ, DEQ, REPLACE), done_t (DONE, WAIT, NEXT_LEVEL), and the KV_EMPTY/ENTRY_EMPTY constant generators.
- kv_t and entry_t are parametrised structs {kv, capacity[LEVELS], active}, declared in the package via a parametrised class or macro so that all levels share them.
- One sub-module is natural: pheap_cmp, the combinational "beats" comparator honoring MAX_HEAP and active bits. It is reused by every level.

Test Plan (LEVELS=3, so MAX_CAP=7; MAX_HEAP=1 unless stated):
- Reset, then ENQ key 5 into empty root:
  - EXEC cycle: done=DONE, head_out.key=5, count=1.
  - Before that: empty=1 after reset.
- Root 5, ENQ 9, children caps L=3 R=2:
  - out.key=5, head_out.key=9, endPos=0, done=NEXT_LEVEL, count=2.
- Same ENQ with nxt_ready held low 3 cycles:
  - done=WAIT for 3 cycles, root unchanged.
  - Commits on the 4th EXEC cycle.
- Root 9, children L=7, R=7 (both active), DEQ:
  - out.key=9, head_out.key=7, endPos=0 (tie goes left), done=NEXT_LEVEL.
- Full (count=7) ENQ 1 -> err pulse 1 cycle, root unchanged.
- Empty DEQ -> err=1, out=KV_EMPTY.
- MAX_HEAP=0, with PHEAP_REPLACE_EN defined:
  - Root 2, children L=4, R=6, REPLACE 3: out.key=2, head_out.key=3, done=DONE.
  - REPLACE 8: head_out.key=4, endPos=0, op_out=REPLACE, done=NEXT_LEVEL.

Source files
------------

// File: rtl/pheap_root_ctl_pkg.sv
// Shared pheap types: opcodes, completion codes and per-level entry structs.
// Optional REPLACE opcode is enabled by defining PHEAP_REPLACE_EN.
`define PHEAP_TYPES(KW, VW, LV) \
  typedef struct packed { \
    logic [(KW)-1:0] key; \
    logic [(VW)-1:0] val; \
  } kv_t; \
  typedef struct packed { \
    kv_t kv; \
    logic [(LV)-1:0] capacity; \
    logic active; \
  } entry_t;

`define PHEAP_CONSTS \
  localparam kv_t KV_EMPTY = '0; \
  localparam entry_t ENTRY_EMPTY = '0;

package pheapTypes;

  typedef enum logic [1:0] {
    ENQ     = 2'd0,
    DEQ     = 2'd1,
    REPLACE = 2'd2
  } opcode_t;

  typedef enum logic [1:0] {
    DONE       = 2'd0,
    WAIT       = 2'd1,
    NEXT_LEVEL = 2'd2
  } done_t;

  function automatic int unsigned max_cap(
    input int unsigned lv
  );
    return (32'd1 << lv) - 32'd1;
  endfunction

endpackage

// File: rtl/pheap_root_ctl_if.sv
// Root controller bus: op request, level-2 child read data, push-down
// handshake and status. REPLACE only legal when PHEAP_REPLACE_EN is defined.
interface pheap_root_ctl_if
  import pheapTypes::*;
#(
  parameter int KEY_W  = 16,
  parameter int VAL_W  = 16,
  parameter int LEVELS = 4
);
  `PHEAP_TYPES(KEY_W, VAL_W, LEVELS)

  logic              start;
  opcode_t           op;
  kv_t               in;
  entry_t            rBotL;
  entry_t            rBotR;
  logic              nxt_ready;
  logic              raddrBot;
  done_t             done;
  opcode_t           op_out;
  logic              endPos;
  kv_t               out;
  kv_t               head_out;
  logic              full;
  logic              empty;
  logic              err;
  logic [LEVELS-1:0] count;

  modport master (
    output start, op, in, rBotL, rBotR, nxt_ready,
    input  raddrBot, done, op_out, endPos, out,
    input  head_out, full, empty, err, count
  );

  modport slave (
    input  start, op, in, rBotL, rBotR, nxt_ready,
    output raddrBot, done, op_out, endPos, out,
    output head_out, full, empty, err, count
  );

endinterface

// File: rtl/pheap_cmp.sv
// "a beats b" comparator shared by all heap levels; an inactive entry
// never beats, an active one beats any inactive one, equal keys never beat.
module pheap_cmp #(
  parameter int KEY_W    = 16,
  parameter int MAX_HEAP = 1
) (
  input  logic             a_act,
  input  logic [KEY_W-1:0] a_key,
  input  logic             b_act,
  input  logic [KEY_W-1:0] b_key,
  output logic             beats
);

  always_comb begin
    beats = 1'b0;
    if (!a_act) begin
      beats = 1'b0;
    end else if (!b_act) begin
      beats = 1'b1;
    end else if (MAX_HEAP != 0) begin
      beats = a_key > b_key;
    end else begin
      beats = a_key < b_key;
    end
  end

endmodule

// File: rtl/pheap_root_ctl.sv
// Level-1 pheap controller: owns the root entry, runs ENQ/DEQ (and REPLACE
// when PHEAP_REPLACE_EN is defined), pushes work down to level 2.
module pheap_root_ctl
  import pheapTypes::*;
#(
  parameter int KEY_W    = 16,
  parameter int VAL_W    = 16,
  parameter int LEVELS   = 4,
  parameter int MAX_HEAP = 1
) (
  input logic clk,
  input logic rst,
  pheap_root_ctl_if.slave bus
);
  `PHEAP_TYPES(KEY_W, VAL_W, LEVELS)
  `PHEAP_CONSTS

  localparam int unsigned MAX_CAP = max_cap(LEVELS);
  localparam logic [LEVELS-1:0] CAP_MAX = LEVELS'(MAX_CAP);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t  state_q, state_d;
  entry_t  root_q, root_d;
  opcode_t op_q, op_d;
  kv_t     in_q, in_d;
  done_t   done_q, done_d;
  logic    err_q, err_d;
  kv_t     out_q, out_d;
  logic    end_q, end_d;
  opcode_t opo_q, opo_d;

  entry_t  r_root;
  done_t   r_done;
  logic    r_err;
  kv_t     r_out;
  logic    r_end;
  opcode_t r_op;

  logic    full;
  logic    empty;
  logic    in_beats_root;
  logic    r_beats_l;
  logic    child_any;
  logic    best_side;
  entry_t  best;

  assign full      = root_q.capacity == '0;
  assign empty     = root_q.capacity == CAP_MAX;
  assign child_any = bus.rBotL.active | bus.rBotR.active;
  assign best_side = r_beats_l;
  assign best      = r_beats_l ? bus.rBotR : bus.rBotL;

  pheap_cmp #(.KEY_W(KEY_W), .MAX_HEAP(MAX_HEAP)) u_cmp_in (
    .a_act (1'b1),
    .a_key (in_q.key),
    .b_act (root_q.active),
    .b_key (root_q.kv.key),
    .beats (in_beats_root)
  );

  pheap_cmp #(.KEY_W(KEY_W), .MAX_HEAP(MAX_HEAP)) u_cmp_ch (
    .a_act (bus.rBotR.active),
    .a_key (bus.rBotR.kv.key),
    .b_act (bus.rBotL.active),
    .b_key (bus.rBotL.kv.key),
    .beats (r_beats_l)
  );

`ifdef PHEAP_REPLACE_EN
  logic best_beats_in;

  pheap_cmp #(.KEY_W(KEY_W), .MAX_HEAP(MAX_HEAP)) u_cmp_rep (
    .a_act (best.active),
    .a_key (best.kv.key),
    .b_act (1'b1),
    .b_key (in_q.key),
    .beats (best_beats_in)
  );
`endif

  // Outcome of the captured op against current root and children.
  always_comb begin
    r_root = root_q;
    r_done = DONE;
    r_err  = 1'b0;
    r_out  = KV_EMPTY;
    r_end  = 1'b0;
    r_op   = op_q;
    unique case (op_q)
      ENQ: begin
        unique case (1'b1)
          full: r_err = 1'b1;
          !full && !root_q.active: begin
            r_root.kv       = in_q;
            r_root.active   = 1'b1;
            r_root.capacity = root_q.capacity - 1'b1;
          end
          default: begin
            r_root.capacity = root_q.capacity - 1'b1;
            if (in_beats_root) begin
              r_root.kv = in_q;
              r_out     = root_q.kv;
            end else begin
              r_out = in_q;
            end
            r_end  = bus.rBotR.capacity > bus.rBotL.capacity;
            r_done = NEXT_LEVEL;
          end
        endcase
      end
      DEQ: begin
        unique case (1'b1)
          empty: r_err = 1'b1;
          !empty && !child_any: begin
            r_out           = root_q.kv;
            r_root          = ENTRY_EMPTY;
            r_root.capacity = root_q.capacity + 1'b1;
          end
          default: begin
            r_out           = root_q.kv;
            r_root.kv       = best.kv;
            r_root.capacity = root_q.capacity + 1'b1;
            r_end           = best_side;
            r_done          = NEXT_LEVEL;
          end
        endcase
      end
`ifdef PHEAP_REPLACE_EN
      REPLACE: begin
        unique case (1'b1)
          !root_q.active: begin
            r_root.kv       = in_q;
            r_root.active   = 1'b1;
            r_root.capacity = root_q.capacity - 1'b1;
          end
          root_q.active && best_beats_in: begin
            r_out     = root_q.kv;
            r_root.kv = best.kv;
            r_end     = best_side;
            r_done    = NEXT_LEVEL;
          end
          default: begin
            r_out     = root_q.kv;
            r_root.kv = in_q;
          end
        endcase
      end
`endif
      default: r_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    root_d  = root_q;
    op_d    = op_q;
    in_d    = in_q;
    done_d  = done_q;
    err_d   = 1'b0;
    out_d   = out_q;
    end_d   = end_q;
    opo_d   = opo_q;
    unique case (state_q)
      IDLE: begin
        done_d = DONE;
        if (bus.start) begin
          op_d    = bus.op;
          in_d    = bus.in;
          done_d  = WAIT;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Hold everything while level 2 cannot take the push-down.
        if (r_done == NEXT_LEVEL && !bus.nxt_ready) begin
          done_d = WAIT;
        end else begin
          root_d  = r_root;
          done_d  = r_done;
          err_d   = r_err;
          out_d   = r_out;
          end_d   = r_end;
          opo_d   = r_op;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      root_q  <= {KV_EMPTY, CAP_MAX, 1'b0};
      op_q    <= ENQ;
      in_q    <= KV_EMPTY;
      done_q  <= DONE;
      err_q   <= 1'b0;
      out_q   <= KV_EMPTY;
      end_q   <= 1'b0;
      opo_q   <= ENQ;
    end else begin
      state_q <= state_d;
      root_q  <= root_d;
      op_q    <= op_d;
      in_q    <= in_d;
      done_q  <= done_d;
      err_q   <= err_d;
      out_q   <= out_d;
      end_q   <= end_d;
      opo_q   <= opo_d;
    end
  end

  assign bus.raddrBot = 1'b0;
  assign bus.done     = done_q;
  assign bus.op_out   = opo_q;
  assign bus.endPos   = end_q;
  assign bus.out      = out_q;
  assign bus.head_out = root_q.kv;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.err      = err_q;
  assign bus.count    = CAP_MAX - root_q.capacity;

endmodule

// File: tb/tb_pheap_root_ctl.sv
// Directed bench for pheap_root_ctl: max-heap and min-heap instances,
// LEVELS=3; REPLACE checks follow PHEAP_REPLACE_EN.
module tb_pheap_root_ctl;
  import pheapTypes::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pheap_root_ctl_if #(.KEY_W(16), .VAL_W(16), .LEVELS(3)) ba ();
  pheap_root_ctl_if #(.KEY_W(16), .VAL_W(16), .LEVELS(3)) bb ();

  pheap_root_ctl #(
    .KEY_W(16), .VAL_W(16), .LEVELS(3), .MAX_HEAP(1)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ba)
  );

  pheap_root_ctl #(
    .KEY_W(16), .VAL_W(16), .LEVELS(3), .MAX_HEAP(0)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bb)
  );

  function automatic logic [35:0] ent(
    input logic [15:0] k, input logic [2:0] cap, input logic act
  );
    return {k, 16'h0000, cap, act};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string tag, input logic [63:0] o, input logic [63:0] e
  );
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic go_a(input opcode_t o, input logic [15:0] k,
                      input logic [15:0] v);
    ba.start = 1'b1;
    ba.op    = o;
    ba.in    = {k, v};
    tick();
    ba.start = 1'b0;
  endtask

  task automatic go_b(input opcode_t o, input logic [15:0] k,
                      input logic [15:0] v);
    bb.start = 1'b1;
    bb.op    = o;
    bb.in    = {k, v};
    tick();
    bb.start = 1'b0;
  endtask

  initial begin
    ba.start = 0; ba.op = ENQ; ba.in = '0; ba.nxt_ready = 1;
    ba.rBotL = '0; ba.rBotR = '0;
    bb.start = 0; bb.op = ENQ; bb.in = '0; bb.nxt_ready = 1;
    bb.rBotL = '0; bb.rBotR = '0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_done", ba.done, DONE);
    chk("rst_empty", ba.empty, 1);
    chk("rst_count", ba.count, 0);
    chk("rst_err", ba.err, 0);
    chk("rst_out", ba.out, 0);
    chk("rst_endpos", ba.endPos, 0);
    chk("rst_opout", ba.op_out, ENQ);
    chk("rst_raddr", ba.raddrBot, 0);

    // ENQ 5 into empty root
    go_a(ENQ, 16'd5, 16'h0);
    chk("enq5_wait", ba.done, WAIT);
    tick();
    chk("enq5_done", ba.done, DONE);
    chk("enq5_head", ba.head_out.key, 5);
    chk("enq5_count", ba.count, 1);
    chk("enq5_empty", ba.empty, 0);

    // ENQ 9, caps L=3 R=2
    ba.rBotL = ent(0, 3'd3, 0); ba.rBotR = ent(0, 3'd2, 0);
    go_a(ENQ, 16'd9, 16'h0);
    tick();
    chk("enq9_done", ba.done, NEXT_LEVEL);
    chk("enq9_out", ba.out.key, 5);
    chk("enq9_head", ba.head_out.key, 9);
    chk("enq9_endpos", ba.endPos, 0);
    chk("enq9_count", ba.count, 2);

    // ENQ 3 with back-pressure, caps L=2 R=3
    ba.rBotL = ent(0, 3'd2, 0); ba.rBotR = ent(0, 3'd3, 0);
    go_a(ENQ, 16'd3, 16'h0);
    ba.nxt_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_wait", ba.done, WAIT);
      chk("bp_head", ba.head_out.key, 9);
      chk("bp_count", ba.count, 2);
    end
    ba.nxt_ready = 1'b1;
    tick();
    chk("bp_done", ba.done, NEXT_LEVEL);
    chk("bp_out", ba.out.key, 3);
    chk("bp_endpos", ba.endPos, 1);
    chk("bp_count3", ba.count, 3);

    // DEQ, children tie at 7 -> left
    ba.rBotL = ent(16'd7, 3'd1, 1); ba.rBotR = ent(16'd7, 3'd1, 1);
    go_a(DEQ, 16'd0, 16'h0);
    tick();
    chk("deq_tie_done", ba.done, NEXT_LEVEL);
    chk("deq_tie_out", ba.out.key, 9);
    chk("deq_tie_head", ba.head_out.key, 7);
    chk("deq_tie_endpos", ba.endPos, 0);
    chk("deq_tie_opout", ba.op_out, DEQ);
    chk("deq_tie_count", ba.count, 2);

    // ENQ equal key: root kept, incoming pushed down
    ba.rBotL = ent(0, 3'd1, 0); ba.rBotR = ent(0, 3'd1, 0);
    go_a(ENQ, 16'd7, 16'hAAAA);
    tick();
    chk("enq_tie_outval", ba.out.val, 16'hAAAA);
    chk("enq_tie_headval", ba.head_out.val, 16'h0000);
    chk("enq_tie_endpos", ba.endPos, 0);
    chk("enq_tie_count", ba.count, 3);

    // DEQ, right child better
    ba.rBotL = ent(16'd4, 3'd1, 1); ba.rBotR = ent(16'd6, 3'd1, 1);
    go_a(DEQ, 16'd0, 16'h0);
    tick();
    chk("deq_r_out", ba.out.key, 7);
    chk("deq_r_head", ba.head_out.key, 6);
    chk("deq_r_endpos", ba.endPos, 1);
    chk("deq_r_count", ba.count, 2);

    // DEQ, only left child active
    ba.rBotL = ent(16'd3, 3'd1, 1); ba.rBotR = ent(0, 3'd3, 0);
    go_a(DEQ, 16'd0, 16'h0);
    tick();
    chk("deq_l_out", ba.out.key, 6);
    chk("deq_l_head", ba.head_out.key, 3);
    chk("deq_l_endpos", ba.endPos, 0);
    chk("deq_l_count", ba.count, 1);

    // DEQ, no active child -> root empties
    ba.rBotL = '0; ba.rBotR = '0;
    go_a(DEQ, 16'd0, 16'h0);
    tick();
    chk("deq_last_done", ba.done, DONE);
    chk("deq_last_out", ba.out.key, 3);
    chk("deq_last_head", ba.head_out, 0);
    chk("deq_last_empty", ba.empty, 1);
    chk("deq_last_count", ba.count, 0);

    // DEQ on empty
    go_a(DEQ, 16'd0, 16'h0);
    tick();
    chk("deq_empty_err", ba.err, 1);
    chk("deq_empty_out", ba.out, 0);
    chk("deq_empty_done", ba.done, DONE);
    tick();
    chk("deq_empty_pulse", ba.err, 0);

    // fill to capacity
    for (int i = 0; i < 7; i++) begin
      go_a(ENQ, 16'(10 + i), 16'h0);
      tick();
    end
    chk("fill_count", ba.count, 7);
    chk("fill_full", ba.full, 1);
    chk("fill_head", ba.head_out.key, 16);

    // ENQ on full
    go_a(ENQ, 16'd1, 16'h0);
    tick();
    chk("enq_full_err", ba.err, 1);
    chk("enq_full_done", ba.done, DONE);
    chk("enq_full_head", ba.head_out.key, 16);
    chk("enq_full_count", ba.count, 7);
    tick();
    chk("enq_full_pulse", ba.err, 0);

`ifdef PHEAP_REPLACE_EN
    go_a(REPLACE, 16'd2, 16'h0);
    tick();
    chk("rep_a_done", ba.done, DONE);
    chk("rep_a_out", ba.out.key, 16);
    chk("rep_a_head", ba.head_out.key, 2);
    chk("rep_a_count", ba.count, 7);
`else
    go_a(REPLACE, 16'd2, 16'h0);
    tick();
    chk("rep_ill_err", ba.err, 1);
    chk("rep_ill_done", ba.done, DONE);
    chk("rep_ill_head", ba.head_out.key, 16);
`endif

    // min-heap instance
    go_b(ENQ, 16'd2, 16'h0);
    tick();
    chk("min_enq2_head", bb.head_out.key, 2);
    chk("min_enq2_count", bb.count, 1);

    bb.rBotL = ent(0, 3'd3, 0); bb.rBotR = ent(0, 3'd3, 0);
    go_b(ENQ, 16'd1, 16'h0);
    tick();
    chk("min_enq1_done", bb.done, NEXT_LEVEL);
    chk("min_enq1_out", bb.out.key, 2);
    chk("min_enq1_head", bb.head_out.key, 1);
    chk("min_enq1_endpos", bb.endPos, 0);

    bb.rBotL = ent(16'd4, 3'd2, 1); bb.rBotR = ent(16'd3, 3'd2, 1);
    go_b(DEQ, 16'd0, 16'h0);
    tick();
    chk("min_deq_out", bb.out.key, 1);
    chk("min_deq_head", bb.head_out.key, 3);
    chk("min_deq_endpos", bb.endPos, 1);
    chk("min_deq_count", bb.count, 1);

    bb.rBotL = ent(16'd4, 3'd2, 1); bb.rBotR = ent(16'd6, 3'd2, 1);
`ifdef PHEAP_REPLACE_EN
    go_b(REPLACE, 16'd2, 16'h0);
    tick();
    chk("min_rep2_done", bb.done, DONE);
    chk("min_rep2_out", bb.out.key, 3);
    chk("min_rep2_head", bb.head_out.key, 2);

    go_b(REPLACE, 16'd8, 16'h0);
    tick();
    chk("min_rep8_done", bb.done, NEXT_LEVEL);
    chk("min_rep8_out", bb.out.key, 2);
    chk("min_rep8_head", bb.head_out.key, 4);
    chk("min_rep8_endpos", bb.endPos, 0);
    chk("min_rep8_opout", bb.op_out, REPLACE);
    chk("min_rep8_count", bb.count, 1);
`else
    go_b(REPLACE, 16'd2, 16'h0);
    tick();
    chk("min_rep_err", bb.err, 1);
    chk("min_rep_head", bb.head_out.key, 3);
    chk("min_rep_count", bb.count, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
